// File: rtl/dvp_frame_gen_if.sv
// DVP capture-side video bus: vsync, href and the pixel byte.
// The master drives all three; the slave only samples them.
interface dvp_frame_gen_if;
   logic       vsync;
   logic       href;
   logic [7:0] pdata;

   modport master (output vsync, href, pdata);
   modport slave  (input  vsync, href, pdata);
endinterface

// File: rtl/dvp_frame_gen.sv
// OV7670-style DVP test-pattern frame generator driving vsync/href/pdata.
// Latency: frame_start one clock after enable is seen at a frame boundary; no backpressure, free-running.
module dvp_frame_gen #(
   parameter int H_PIXELS    = 320,
   parameter int V_LINES     = 240,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [1:0]             pattern_sel,
   input  logic [7:0]             const_data,
   dvp_frame_gen_if.master        dvp,
   output logic                   frame_start,
   output logic                   frame_done,
   output logic                   busy,
   output logic [15:0]            frame_cnt
);

   localparam int LINE_LEN  = 2 * H_PIXELS + H_BLANK;
   localparam int BYTES     = 2 * H_PIXELS;
   localparam int MAX_VB    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int MAX_FA    = (V_FRONT > V_LINES) ? V_FRONT : V_LINES;
   localparam int MAX_LINES = (MAX_VB > MAX_FA) ? MAX_VB : MAX_FA;
   localparam int COL_W     = ($clog2(LINE_LEN) > 10) ? $clog2(LINE_LEN) : 10;
   localparam int LN_W      = ($clog2(MAX_LINES) > 9) ? $clog2(MAX_LINES) : 9;

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_LEN - 1);
   localparam logic [COL_W-1:0] ACT_BYTES  = COL_W'(BYTES);
   localparam logic [LN_W-1:0]  FRONT_LAST = LN_W'(V_FRONT - 1);

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

   state_t           state;
   logic [COL_W-1:0] col;
   logic [COL_W-1:0] col_nxt;
   logic [LN_W-1:0]  line;
   logic [LN_W-1:0]  line_nxt;
   logic [LN_W-1:0]  seg_last;
   logic             line_end;
   logic             seg_end;
   logic [1:0]       pat_q;
   logic [7:0]       const_q;

   // col counts clocks inside one line period, line counts line periods inside the current state
   always_comb begin
      seg_last = '0;
      case (state)
         VSYNC:   seg_last = LN_W'(VSYNC_LINES - 1);
         VBACK:   seg_last = LN_W'(V_BACK - 1);
         ACTIVE:  seg_last = LN_W'(V_LINES - 1);
         VFRONT:  seg_last = FRONT_LAST;
         default: seg_last = '0;
      endcase
      line_end = (col == COL_LAST);
      seg_end  = line_end && (line == seg_last);
      col_nxt  = line_end ? '0 : col + 1'b1;
      line_nxt = seg_end ? '0 : (line_end ? line + 1'b1 : line);
   end

   function automatic logic [7:0] pix(input logic [1:0] p, input logic [7:0] k,
                                      input logic [7:0] b, input logic [7:0] y);
      case (p)
         2'd0:    return b;
         2'd1:    return y;
         2'd2:    return k;
         default: return {y[3:0], b[4:1]};
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         line        <= '0;
         pat_q       <= '0;
         const_q     <= '0;
         dvp.vsync   <= 1'b0;
         dvp.href    <= 1'b0;
         dvp.pdata   <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state       <= VSYNC;
                  col         <= '0;
                  line        <= '0;
                  pat_q       <= pattern_sel;
                  const_q     <= const_data;
                  frame_start <= 1'b1;
                  dvp.vsync   <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            VSYNC: begin
               col  <= col_nxt;
               line <= line_nxt;
               if (seg_end) begin
                  state     <= VBACK;
                  dvp.vsync <= 1'b0;
               end
            end
            VBACK: begin
               col  <= col_nxt;
               line <= line_nxt;
               if (seg_end) begin
                  state     <= ACTIVE;
                  dvp.href  <= 1'b1;
                  dvp.pdata <= pix(pat_q, const_q, 8'd0, 8'd0);
               end
            end
            ACTIVE: begin
               col  <= col_nxt;
               line <= line_nxt;
               if (seg_end) begin
                  state     <= VFRONT;
                  dvp.href  <= 1'b0;
                  dvp.pdata <= '0;
               end else if (col_nxt < ACT_BYTES) begin
                  dvp.href  <= 1'b1;
                  dvp.pdata <= pix(pat_q, const_q, col_nxt[7:0], line_nxt[7:0]);
               end else begin
                  dvp.href  <= 1'b0;
                  dvp.pdata <= '0;
               end
            end
            VFRONT: begin
               col  <= col_nxt;
               line <= line_nxt;
               // raise frame_done so it is visible during the final VFRONT clock
               if (line_nxt == FRONT_LAST && col_nxt == COL_LAST)
                  frame_done <= 1'b1;
               if (seg_end) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  if (enable) begin
                     state       <= VSYNC;
                     pat_q       <= pattern_sel;
                     const_q     <= const_data;
                     frame_start <= 1'b1;
                     dvp.vsync   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Scoreboard bench for dvp_frame_gen: per-line length/hash expectations queued at frame_start.
// Reduced geometry keeps each frame short while still wrapping the byte index past 255.
module tb_dvp_frame_gen;

   localparam int HP = 130, VL = 18, HB = 4, VS = 2, VBK = 2, VF = 2;
   localparam int LINE_LEN  = 2 * HP + HB;
   localparam int FRAME_LEN = (VS + VBK + VL + VF) * LINE_LEN;

   typedef struct {
      int unsigned len;
      int unsigned hash;
   } line_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [7:0]  const_data;
   logic        frame_start, frame_done, busy;
   logic [15:0] frame_cnt;

   dvp_frame_gen_if dvp();

   dvp_frame_gen #(
      .H_PIXELS(HP), .V_LINES(VL), .H_BLANK(HB),
      .VSYNC_LINES(VS), .V_BACK(VBK), .V_FRONT(VF)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pattern_sel(pattern_sel), .const_data(const_data),
      .dvp(dvp),
      .frame_start(frame_start), .frame_done(frame_done),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   line_exp_t line_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int pat, input logic [7:0] k, input int b, input int y);
      case (pat)
         0:       return 8'(b % 256);
         1:       return 8'(y % 256);
         2:       return k;
         default: return 8'(((y % 16) * 16) + ((b / 2) % 16));
      endcase
   endfunction

   task automatic push_frame(input int pat, input logic [7:0] k);
      line_exp_t e;
      for (int y = 0; y < VL; y++) begin
         e.len  = 2 * HP;
         e.hash = 0;
         for (int b = 0; b < 2 * HP; b++)
            e.hash = e.hash * 31 + {24'd0, exp_byte(pat, k, b, y)};
         line_q.push_back(e);
      end
   endtask

   always @(negedge clk)
      if (!reset && frame_start) push_frame(int'(pattern_sel), const_data);

   // line collector: compares each finished href pulse against the queue head
   int          lines_seen = 0;
   int          idle_nonzero = 0;
   bit          in_line = 0;
   int unsigned cur_len, cur_hash;
   line_exp_t   got_e;

   always @(negedge clk) begin
      if (reset) begin
         in_line = 0;
      end else if (dvp.href) begin
         if (!in_line) begin
            in_line  = 1;
            cur_len  = 0;
            cur_hash = 0;
         end
         cur_len++;
         cur_hash = cur_hash * 31 + {24'd0, dvp.pdata};
      end else begin
         if (dvp.pdata !== 8'h00) idle_nonzero++;
         if (in_line) begin
            in_line = 0;
            lines_seen++;
            if (line_q.size() == 0) begin
               check("line_unexpected", 1, 0);
            end else begin
               got_e = line_q.pop_front();
               check("line_len", cur_len, got_e.len);
               check("line_data", cur_hash, got_e.hash);
            end
         end
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic cond(input int which);
      case (which)
         0:       return frame_start;
         1:       return frame_done;
         2:       return dvp.href;
         3:       return !dvp.vsync;
         default: return !dvp.href;
      endcase
   endfunction

   task automatic wait_for(input int which, input int max, output int n);
      n = 0;
      while (!cond(which) && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!cond(which)) check($sformatf("timeout_%0d", which), 0, 1);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_vsync"}, dvp.vsync, 0);
      check({pfx, "_href"}, dvp.href, 0);
      check({pfx, "_pdata"}, dvp.pdata, 0);
      check({pfx, "_fstart"}, frame_start, 0);
      check({pfx, "_fdone"}, frame_done, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_fcnt"}, frame_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, sum, busy_seen;
      logic [7:0] vals [3];
      vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h5A;

      reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; const_data = 8'h00;
      repeat (3) tick;
      check_zero("rst");
      reset = 1'b0;
      tick;

      // abort an active frame with reset
      pattern_sel = 2'd1; enable = 1'b1;
      tick;
      check("abort_fstart", frame_start, 1);
      enable = 1'b0;
      wait_for(2, 4 * LINE_LEN, n);
      repeat (5) tick;
      reset = 1'b1;
      tick;
      check_zero("abort");
      tick;
      reset = 1'b0;
      line_q.delete();
      busy_seen = 0;
      for (int i = 0; i < 2 * LINE_LEN; i++) begin
         tick;
         if (busy || frame_done) busy_seen++;
      end
      check("abort_stays_idle", busy_seen, 0);

      // frame timing, pattern 0, enable dropped mid-frame
      pattern_sel = 2'd0; enable = 1'b1;
      tick;
      check("f1_fstart", frame_start, 1);
      check("f1_vsync", dvp.vsync, 1);
      check("f1_busy", busy, 1);
      wait_for(3, 4 * FRAME_LEN, n);
      check("vsync_len", n, VS * LINE_LEN);
      sum = n;
      wait_for(2, 4 * FRAME_LEN, n);
      check("vback_len", n, VBK * LINE_LEN);
      sum += n;
      for (int l = 0; l < 10; l++) begin
         wait_for(4, 2 * LINE_LEN, n); sum += n;
         wait_for(2, 2 * LINE_LEN, n); sum += n;
      end
      enable = 1'b0;
      wait_for(1, 2 * FRAME_LEN, n);
      sum += n;
      check("frame_len", sum + 1, FRAME_LEN);
      check("f1_queue_drained", line_q.size(), 0);
      tick;
      check("f1_cnt", frame_cnt, 1);
      check("f1_idle_busy", busy, 0);
      check("f1_no_restart", frame_start, 0);

      // pattern 3 spot-check on line 17
      pattern_sel = 2'd3; enable = 1'b1;
      tick;
      check("p3_fstart", frame_start, 1);
      enable = 1'b0;
      for (int l = 0; l < VL; l++) begin
         wait_for(2, 4 * FRAME_LEN, n);
         if (l < VL - 1) wait_for(4, 2 * LINE_LEN, n);
      end
      check("p3_b0", dvp.pdata, 8'h10);
      tick;
      check("p3_b1", dvp.pdata, 8'h10);
      tick;
      check("p3_b2", dvp.pdata, 8'h11);
      wait_for(1, 2 * FRAME_LEN, n);
      tick;
      check("p3_cnt", frame_cnt, 2);
      check("p3_idle_busy", busy, 0);

      reset = 1'b1;
      repeat (2) tick;
      reset = 1'b0;
      check("rst2_cnt", frame_cnt, 0);

      // three back-to-back constant frames, const_data changed mid-frame
      pattern_sel = 2'd2; const_data = 8'hA5; enable = 1'b1;
      tick;
      check("b2b_first_fstart", frame_start, 1);
      for (int f = 0; f < 3; f++) begin
         wait_for(2, 4 * FRAME_LEN, n);
         const_data = vals[f];
         if (f == 2) enable = 1'b0;
         wait_for(1, 2 * FRAME_LEN, n);
         tick;
         if (f < 2) check($sformatf("b2b_fstart_%0d", f), frame_start, 1);
         else       check("b2b_last_idle", busy, 0);
      end
      check("b2b_cnt", frame_cnt, 3);
      check("b2b_queue_drained", line_q.size(), 0);
      check("lines_total", lines_seen, 5 * VL);
      check("pdata_zero_when_href_low", idle_nonzero, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dvp_frame_gen.md
DVP_FRAME_GEN -- requirements
Module: dvp_frame_gen

Interface
REQ-001 The module SHALL have parameter H_PIXELS, default 320, meaning active pixels per line (2 bytes per pixel).
REQ-002 The module SHALL have parameter V_LINES, default 240, meaning active lines per frame.
REQ-003 The module SHALL have parameter H_BLANK, default 144, meaning href-low clocks after each active line.
REQ-004 The module SHALL have parameter VSYNC_LINES, default 3, meaning line periods with vsync high.
REQ-005 The module SHALL have parameter V_BACK, default 17, meaning blank line periods after vsync and before the first active line.
REQ-006 The module SHALL have parameter V_FRONT, default 10, meaning blank line periods after the last active line.
REQ-007 The module SHALL have port clk, input, 1 bit: the byte clock; all outputs change only on its rising edge.
REQ-008 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The module SHALL have port enable, input, 1 bit: run request, sampled only at frame boundaries.
REQ-010 The module SHALL have port pattern_sel, input, 2 bits: test pattern selection.
REQ-011 The module SHALL have port const_data, input, 8 bits: byte value for constant mode.
REQ-012 The module SHALL have outputs vsync (1 bit), href (1 bit) and pdata (8 bits), with OV7670 DVP capture-side semantics.
REQ-013 The module SHALL have outputs frame_start and frame_done, 1 bit each: single-cycle pulses.
REQ-014 The module SHALL have output busy, 1 bit: high while a frame is in progress.
REQ-015 The module SHALL have output frame_cnt, 16 bits: count of completed frames.

Function
REQ-016 The module SHALL define LINE_LEN = 2*H_PIXELS + H_BLANK clocks as one line period.
REQ-017 The module SHALL implement FSM states IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
REQ-018 In IDLE with enable=1, the next cycle SHALL enter VSYNC with frame_start=1 for exactly that cycle, and pattern_sel and const_data SHALL be latched for the whole frame.
REQ-019 The module SHALL hold vsync=1 for exactly VSYNC_LINES*LINE_LEN clocks in VSYNC, and vsync=0 in every other state.
REQ-020 VBACK SHALL last V_BACK*LINE_LEN clocks with href=0.
REQ-021 ACTIVE SHALL contain V_LINES line periods, each with href=1 for the first 2*H_PIXELS clocks and href=0 for the remaining H_BLANK clocks.
REQ-022 VFRONT SHALL last V_FRONT*LINE_LEN clocks; on its last cycle frame_done=1 and frame_cnt increments.
REQ-023 At the end of VFRONT, the FSM SHALL go to VSYNC (with a frame_start pulse) if enable=1, else to IDLE; frames SHALL be back-to-back with no gap cycle.
REQ-024 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame always completes.
REQ-025 The module SHALL use byte index b (0..2*H_PIXELS-1) within a line, pixel x = b>>1, and line index y (0..V_LINES-1).
REQ-026 pattern_sel=0 SHALL drive pdata = b[7:0], wrapping modulo 256.
REQ-027 pattern_sel=1 SHALL drive pdata = y[7:0].
REQ-028 pattern_sel=2 SHALL drive pdata = latched const_data.
REQ-029 pattern_sel=3 SHALL drive pdata = {y[3:0], x[3:0]}.
REQ-030 pdata SHALL be 8'h00 whenever href=0.
REQ-031 The module SHALL assert busy in every state except IDLE.
REQ-032 frame_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-033 All counters SHALL be sized for the default parameters with no overflow: a 10-bit column counter, a 9-bit line counter, and a line-period counter up to the largest of VSYNC_LINES, V_BACK, V_FRONT and V_LINES.

Reset
REQ-034 On reset=1, the module SHALL, on the next clk edge, force state=IDLE and vsync=0, href=0, pdata=0, frame_start=0, frame_done=0, busy=0, frame_cnt=0, and clear all counters.
REQ-035 A reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.

Verification
REQ-036 Scenario: reset, enable=1, defaults -> frame_start one cycle after enable; vsync high for 3*784=2352 clocks; then 17*784 clocks with href=0; first href rise follows.
REQ-037 Scenario: pattern_sel=0, one full frame -> 240 href pulses of 640 clocks each; each line's pdata is 0..255,0..255,0..127; total frame 270*784=211680 clocks.
REQ-038 Scenario: pattern_sel=3, line y=17 -> pdata at b=0,1,2 equals 8'h10,8'h10,8'h11.
REQ-039 Scenario: enable dropped at line 100 of frame 1 -> frame completes, frame_done pulses, frame_cnt=1, FSM returns to IDLE, busy=0.
REQ-040 Scenario: reset pulsed during ACTIVE -> all outputs zero the next cycle, no frame_done pulse, frame_cnt unchanged at 0.
REQ-041 Scenario: enable held high for 3 frames, with const_data changed mid-frame in pattern_sel=2 -> back-to-back frames with no gap, frame_cnt=3, each frame shows only the value latched at its frame_start.
